// File: rtl/flip_encoder_stream.sv
// flip_encoder_stream: write-side flip encoder for stuck-at tolerant memory rows.
// Each accepted word is compared against its stuck-at fault map. If storing the
// inverted word hits fewer stuck cells, the word is stored inverted and flagged.
// Two-stage valid/ready pipeline (S1 operand register, S2 decision/output register).
// Optional feature macro: FLIP_ENC_ERRCNT_EN builds the residual-conflict counters
// (out_err, blk_err). Without it, both outputs are tied to zero.
module flip_encoder_stream #(
  parameter int N  = 16,
  parameter int M  = 16,
  parameter int CW = $clog2(N + 1),
  parameter int IW = (M > 1) ? $clog2(M) : 1,
  parameter int BW = CW + $clog2(M) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [N-1:0]  in_mask,
  input  logic [N-1:0]  in_sval,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_flip,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic [CW-1:0] out_err,
  output logic [BW-1:0] blk_err
);

  // Counts the set bits of a word; the result always fits in CW bits.
  function automatic logic [CW-1:0] f_popcount(input logic [N-1:0] v);
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc + CW'(v[i]);
    end
    return acc;
  endfunction

  logic          r_s1Valid;
  logic [N-1:0]  r_s1Data;
  logic [N-1:0]  r_s1Mask;
  logic [N-1:0]  r_s1Sval;

  logic          r_outValid;
  logic [N-1:0]  r_outData;
  logic          r_outFlip;
  logic [IW-1:0] r_outIdx;
  logic          r_outLast;
  logic [IW-1:0] r_cnt;

  logic          w_s2Load;
  logic          w_s1Load;
  logic [N-1:0]  w_diff;
  logic [CW-1:0] w_c0;
  logic [CW-1:0] w_c1;
  logic          w_flip;
  logic          w_cntLast;
  logic [IW-1:0] w_cntNext;

  // Pipeline advance: S2 refills when empty or drained this cycle; S1 follows S2.
  always_comb begin
    w_s2Load = !r_outValid || out_ready;
    w_s1Load = !r_s1Valid || w_s2Load;
  end

  assign in_ready = !rst && w_s1Load;

  // Flip decision on the S1 word: c0 = conflicts stored as-is, c1 = conflicts stored inverted.
  always_comb begin
    w_diff = r_s1Mask & (r_s1Data ^ r_s1Sval);
    w_c0   = f_popcount(w_diff);
`ifdef FLIP_ENC_ERRCNT_EN
    w_c1   = f_popcount(r_s1Mask) - w_c0;
`else
    w_c1   = f_popcount(r_s1Mask & ~(r_s1Data ^ r_s1Sval));
`endif
    w_flip = (w_c1 < w_c0);
  end

  // Position of the next word within its block; the counter value itself encodes first/mid/last.
  always_comb begin
    w_cntLast = (r_cnt == IW'(M - 1));
    w_cntNext = w_cntLast ? '0 : r_cnt + IW'(1);
  end

  // S1 operand register: captures an input beat whenever it has room.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_s1Mask  <= '0;
      r_s1Sval  <= '0;
    end else if (w_s1Load) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Data <= in_data;
        r_s1Mask <= in_mask;
        r_s1Sval <= in_sval;
      end
    end
  end

  // S2 output register plus word counter: the counter advances with each word handed to S2,
  // so every word leaving the block carries its own index and last flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outFlip  <= 1'b0;
      r_outIdx   <= '0;
      r_outLast  <= 1'b0;
      r_cnt      <= '0;
    end else if (w_s2Load) begin
      r_outValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outData <= w_flip ? ~r_s1Data : r_s1Data;
        r_outFlip <= w_flip;
        r_outIdx  <= r_cnt;
        r_outLast <= w_cntLast;
        r_cnt     <= w_cntNext;
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_flip  = r_outFlip;
  assign out_idx   = r_outIdx;
  assign out_last  = r_outLast;

`ifdef FLIP_ENC_ERRCNT_EN
  logic          w_outFire;
  logic [CW-1:0] w_err;
  logic [CW-1:0] r_outErr;
  logic [BW-1:0] r_blkErr;

  // Residual conflicts of the chosen encoding, and the handshake strobe for block framing.
  always_comb begin
    w_err     = w_flip ? w_c1 : w_c0;
    w_outFire = r_outValid && out_ready;
  end

  // Block accumulator: restarts on a block's first word, clears once the last word leaves with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outErr <= '0;
      r_blkErr <= '0;
    end else if (w_s2Load && r_s1Valid) begin
      r_outErr <= w_err;
      r_blkErr <= (r_cnt == '0) ? BW'(w_err) : r_blkErr + BW'(w_err);
    end else if (w_outFire && r_outLast) begin
      r_blkErr <= '0;
    end
  end

  assign out_err = r_outErr;
  assign blk_err = r_blkErr;
`else
  assign out_err = '0;
  assign blk_err = '0;
`endif

endmodule

// File: tb/tb_flip_encoder_stream.sv
// tb_flip_encoder_stream: directed and random stimulus for flip_encoder_stream,
// checked against a word-level model (expected-word queue, block position counter).
module tb_flip_encoder_stream;

  localparam int N = 16;
  localparam int M = 16;
`ifdef FLIP_ENC_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] in_mask;
  logic [15:0] in_sval;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_flip;
  logic [3:0]  out_idx;
  logic        out_last;
  logic [4:0]  out_err;
  logic [9:0]  blk_err;

  flip_encoder_stream #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .in_sval(in_sval),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flip(out_flip), .out_idx(out_idx),
    .out_last(out_last), .out_err(out_err), .blk_err(blk_err)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        flip;
    int          err;
    int          acceptCycle;
  } exp_t;

  exp_t        q[$];
  int          nCompared   = 0;
  int          nMismatched = 0;
  int          outCount    = 0;
  int          blkAcc      = 0;
  int          cycleNo     = 0;
  int          lastLatency = -1;
  bit          prevStalled = 1'b0;
  logic [15:0] prevData;
  logic        prevFlip;
  logic [3:0]  prevIdx;
  logic        prevLast;
  logic [4:0]  prevErr;
  logic [9:0]  prevBlk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Stuck cells disagreeing with the word cost a conflict if stored as-is;
  // stuck cells agreeing with it cost a conflict if stored inverted.
  function automatic exp_t modelWord(input logic [15:0] d, input logic [15:0] m, input logic [15:0] s);
    exp_t r;
    int keep = 0;
    int inv  = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        if (d[i] != s[i]) keep++;
        else inv++;
      end
    end
    r.flip        = (inv < keep);
    r.data        = r.flip ? ~d : d;
    r.err         = r.flip ? inv : keep;
    r.acceptCycle = 0;
    return r;
  endfunction

  // Compares a stalled beat against its snapshot, and a consumed beat against the model.
  task automatic checkOutput();
    exp_t e;
    int   idx;
    if (prevStalled) begin
      check("holdValid", out_valid, 1);
      check("holdData", out_data, prevData);
      check("holdFlip", out_flip, prevFlip);
      check("holdIdx", out_idx, prevIdx);
      check("holdLast", out_last, prevLast);
      check("holdErr", out_err, prevErr);
      check("holdBlk", blk_err, prevBlk);
    end
    if (out_valid && out_ready) begin
      check("outExpected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e   = q.pop_front();
        idx = outCount % M;
        blkAcc = (idx == 0) ? e.err : blkAcc + e.err;
        check("outData", out_data, e.data);
        check("outFlip", out_flip, e.flip);
        check("outIdx", out_idx, idx);
        check("outLast", out_last, idx == M - 1);
        check("outErr", out_err, ERRCNT ? e.err : 0);
        check("blkErr", blk_err, ERRCNT ? blkAcc : 0);
        lastLatency = cycleNo - e.acceptCycle;
        outCount++;
      end
    end
  endtask

  // One clock cycle: drive inputs after the rising edge, observe at the falling edge.
  task automatic applyStimulus(input bit iRst, input bit iValid, input logic [15:0] d,
                               input logic [15:0] m, input logic [15:0] s, input bit oReady);
    exp_t e;
    rst = iRst; in_valid = iValid; in_data = d; in_mask = m; in_sval = s; out_ready = oReady;
    @(negedge clk);
    if (iRst) begin
      check("inReadyInReset", in_ready, 0);
      q.delete();
      outCount    = 0;
      blkAcc      = 0;
      prevStalled = 1'b0;
    end else begin
      checkOutput();
      if (iValid && in_ready) begin
        e = modelWord(d, m, s);
        e.acceptCycle = cycleNo;
        q.push_back(e);
      end
      prevStalled = out_valid && !out_ready;
      prevData = out_data; prevFlip = out_flip; prevIdx = out_idx;
      prevLast = out_last; prevErr = out_err; prevBlk = blk_err;
    end
    cycleNo++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] randMask();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic randBeat(input bit iValid, input bit oReady);
    applyStimulus(1'b0, iValid, 16'($urandom), randMask(), 16'($urandom), oReady);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_sval = '0; out_ready = 1'b0;
    #1;
    repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);

    // Reset values once reset is released.
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rstInReady", in_ready, 1);
    check("rstOutValid", out_valid, 0);
    check("rstOutData", out_data, 0);
    check("rstOutFlip", out_flip, 0);
    check("rstOutIdx", out_idx, 0);
    check("rstOutLast", out_last, 0);
    check("rstOutErr", out_err, 0);
    check("rstBlkErr", blk_err, 0);
    cycleNo++;
    @(posedge clk);
    #1;

    // Flip case, with the two-cycle latency measured.
    applyStimulus(1'b0, 1'b1, 16'h00FF, 16'hFFFF, 16'hFF00, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    check("latency", lastLatency, 2);

    // Tie case keeps the word as-is.
    applyStimulus(1'b0, 1'b1, 16'h0001, 16'h0003, 16'h0003, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    check("tieCount", outCount, 2);

    // Full block of single-stuck-bit words, then a random block, then idle.
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0000, 1'b1);
    for (int i = 0; i < 16; i++) randBeat(1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    check("blockCount", outCount, 32);
    check("blkErrClearedAfterLast", blk_err, 0);

    // Backpressure: five stalled cycles with the source still pushing.
    for (int i = 0; i < 4; i++) randBeat(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) randBeat(1'b1, 1'b0);
    #1;
    check("inReadyStalled", in_ready, 0);
    for (int i = 0; i < 4; i++) randBeat(1'b1, 1'b1);

    // Random traffic on both sides.
    for (int i = 0; i < 300; i++) randBeat($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    // Reset in the middle of a block discards in-flight words and restarts the block.
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 7; i++) randBeat(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h1234, 16'hFFFF, 16'h0000, 1'b1);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("outValidAfterReset", out_valid, 0);
    check("inReadyAfterReset", in_ready, 1);
    cycleNo++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) randBeat(1'b1, 1'b1);

    // Bounded drain of everything still in flight.
    for (int i = 0; i < 20 && q.size() != 0; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    check("drainEmpty", q.size(), 0);
    check("postResetCount", outCount, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
